paper_fetch_sched: RTL and testbench

//  Framebuffer read scheduler for the paper HDMI pipeline, in the AXI clock domain.
//  Per frame, walks the framebuffer line by line and issues AXI4 INCR read bursts
//  (AR channel only) to the pixel FIFO front end. Throttles on FIFO credit and an

---
 rtl/paper_fetch_sched_if.sv | 15 +
 rtl/paper_fetch_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_paper_fetch_sched.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/paper_fetch_sched_if.sv
// AR request / R-beat bundle between the framebuffer fetch scheduler and the
// pixel FIFO front end.
interface paper_fetch_sched_if #(
    parameter int AddrWidth = 64
) ();
    logic [AddrWidth-1:0] ar_addr;
    logic [7:0]           ar_len;
    logic                 ar_valid;
    logic                 ar_ready;
    logic                 r_beat;
    logic                 r_last;

    modport master (output ar_addr, ar_len, ar_valid, input ar_ready, r_beat, r_last);
    modport slave  (input ar_addr, ar_len, ar_valid, output ar_ready, r_beat, r_last);
endinterface

// File: rtl/paper_fetch_sched.sv
// Framebuffer read scheduler: walks a frame line by line issuing 4 KiB-safe AR bursts.
// Optional double buffering (fb_base_alt_i / swap_req_i / cur_buf_o) under PAPER_FETCH_DBLBUF_EN.
module paper_fetch_sched #(
    parameter int AxiAddrWidth   = 64,
    parameter int AxiDataWidth   = 64,
    parameter int BurstLen       = 16,
    parameter int FifoDepth      = 512,
    parameter int MaxOutstanding = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic [AxiAddrWidth-1:0]     fb_base_i,
    input  logic [15:0]                 line_bytes_i,
    input  logic [15:0]                 stride_i,
    input  logic [15:0]                 lines_i,
    input  logic                        frame_start_i,
    input  logic [$clog2(FifoDepth):0]  fifo_fill_i,
`ifdef PAPER_FETCH_DBLBUF_EN
    input  logic [AxiAddrWidth-1:0]     fb_base_alt_i,
    input  logic                        swap_req_i,
    output logic                        cur_buf_o,
`endif
    paper_fetch_sched_if.master         axi,
    output logic                        busy_o,
    output logic                        frame_done_o,
    output logic                        late_o,
    output logic                        cfg_err_o
);
    localparam int BeatBytes = AxiDataWidth / 8;
    localparam int BeatShift = $clog2(BeatBytes);
    localparam int FillW     = $clog2(FifoDepth) + 1;
    localparam int CntW      = FillW + 2;
    localparam int OutW      = $clog2(MaxOutstanding + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_FS = 3'd1;
    localparam logic [2:0] S_CALC    = 3'd2;
    localparam logic [2:0] S_REQ     = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    logic [2:0]              state_r, state_nx_s;
    logic [AxiAddrWidth-1:0] line_addr_r, ar_addr_r, cur_addr_s, sel_base_s;
    logic [15:0]             line_bytes_r, stride_r, lines_r, line_r, off_r, rem_beats_s;
    logic [12:0]             bnd_beats_s;
    logic [16:0]             off_adv_s;
    logic [8:0]              beats_s, beats_r;
    logic [7:0]              ar_len_r;
    logic [CntW-1:0]         inflight_r;
    logic [OutW-1:0]         outstanding_r;
    logic                    ar_valid_r, full_r, busy_r, frame_done_r, late_r, cfg_err_r, en_q_r;
    logic                    ar_hs_s, cfg_bad_s, accept_s, credit_ok_s, out_ok_s, line_end_s, last_line_s;

    function automatic logic addr_misaligned(input logic [AxiAddrWidth-1:0] a);
        return |(a & AxiAddrWidth'(BeatBytes - 1));
    endfunction

    function automatic logic len_misaligned(input logic [15:0] n);
        return |(n & 16'(BeatBytes - 1));
    endfunction

`ifdef PAPER_FETCH_DBLBUF_EN
    logic cur_buf_r, swap_pend_r;
    // The base a frame would start from if accepted now (pending swap applied).
    assign sel_base_s = (cur_buf_r ^ swap_pend_r) ? fb_base_alt_i : fb_base_i;
    assign cur_buf_o  = cur_buf_r;

    // Active-buffer select: a swap request takes effect at the next accepted frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_buf_r   <= 1'b0;
            swap_pend_r <= 1'b0;
        end else if (accept_s) begin
            cur_buf_r   <= cur_buf_r ^ swap_pend_r;
            swap_pend_r <= swap_req_i;
        end else begin
            swap_pend_r <= swap_pend_r | swap_req_i;
        end
    end
`else
    assign sel_base_s = fb_base_i;
`endif

    assign cfg_bad_s   = (line_bytes_i == 16'd0) || (lines_i == 16'd0) ||
                         len_misaligned(line_bytes_i) || addr_misaligned(sel_base_s);
    assign accept_s    = (state_r == S_WAIT_FS) && en_i && frame_start_i && !cfg_bad_s;
    assign ar_hs_s     = ar_valid_r & axi.ar_ready;

    // Burst sizing: the smallest of burst cap, rest of line and room before the 4 KiB page end.
    assign cur_addr_s  = line_addr_r + AxiAddrWidth'(off_r);
    assign rem_beats_s = (line_bytes_r - off_r) >> BeatShift;
    assign bnd_beats_s = (13'h1000 - {1'b0, cur_addr_s[11:0]}) >> BeatShift;
    assign beats_s     = (17'(rem_beats_s) < 17'(BurstLen)) ?
                         ((17'(bnd_beats_s) < 17'(rem_beats_s)) ? 9'(bnd_beats_s) : 9'(rem_beats_s)) :
                         ((17'(bnd_beats_s) < 17'(BurstLen))    ? 9'(bnd_beats_s) : 9'(BurstLen));
    assign credit_ok_s = (CntW'(fifo_fill_i) + inflight_r + CntW'(beats_s)) <= CntW'(FifoDepth);
    assign out_ok_s    = outstanding_r < OutW'(MaxOutstanding);
    assign off_adv_s   = {1'b0, off_r} + (17'(beats_r) << BeatShift);
    assign line_end_s  = off_adv_s >= {1'b0, line_bytes_r};
    assign last_line_s = (line_r + 16'd1) == lines_r;

    // Next-state logic of the frame walker.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (en_i) state_nx_s = S_WAIT_FS;
                else      state_nx_s = S_IDLE;
            end
            S_WAIT_FS: begin
                if (!en_i)         state_nx_s = S_IDLE;
                else if (accept_s) state_nx_s = S_CALC;
                else               state_nx_s = S_WAIT_FS;
            end
            S_CALC: begin
                if (!en_i)                       state_nx_s = S_DRAIN;
                else if (credit_ok_s && out_ok_s) state_nx_s = S_REQ;
                else                              state_nx_s = S_CALC;
            end
            S_REQ: begin
                if (!ar_hs_s)                                    state_nx_s = S_REQ;
                else if (!en_i || (line_end_s && last_line_s))   state_nx_s = S_DRAIN;
                else                                             state_nx_s = S_CALC;
            end
            S_DRAIN: begin
                if ((outstanding_r == {OutW{1'b0}}) && (inflight_r == {CntW{1'b0}}))
                    state_nx_s = en_i ? S_WAIT_FS : S_IDLE;
                else
                    state_nx_s = S_DRAIN;
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register, status pulses and sticky error flags (cleared on rising enable).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= S_IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            late_r       <= 1'b0;
            cfg_err_r    <= 1'b0;
            en_q_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            busy_r       <= (state_nx_s == S_CALC) || (state_nx_s == S_REQ) || (state_nx_s == S_DRAIN);
            frame_done_r <= (state_r == S_DRAIN) && (state_nx_s != S_DRAIN) && full_r;
            en_q_r       <= en_i;
            if (en_i && !en_q_r) begin
                late_r    <= 1'b0;
                cfg_err_r <= 1'b0;
            end else begin
                late_r    <= late_r | (frame_start_i & busy_r);
                cfg_err_r <= cfg_err_r |
                             ((state_r == S_WAIT_FS) & en_i & frame_start_i & cfg_bad_s);
            end
        end
    end

    // Frame geometry latch, line/offset walk and the AR request registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_addr_r  <= {AxiAddrWidth{1'b0}};
            line_bytes_r <= 16'd0;
            stride_r     <= 16'd0;
            lines_r      <= 16'd0;
            line_r       <= 16'd0;
            off_r        <= 16'd0;
            full_r       <= 1'b0;
            ar_valid_r   <= 1'b0;
            ar_addr_r    <= {AxiAddrWidth{1'b0}};
            ar_len_r     <= 8'd0;
            beats_r      <= 9'd0;
        end else if (accept_s) begin
            line_addr_r  <= sel_base_s;
            line_bytes_r <= line_bytes_i;
            stride_r     <= stride_i;
            lines_r      <= lines_i;
            line_r       <= 16'd0;
            off_r        <= 16'd0;
            full_r       <= 1'b0;
        end else if ((state_r == S_CALC) && (state_nx_s == S_REQ)) begin
            ar_valid_r   <= 1'b1;
            ar_addr_r    <= cur_addr_s;
            ar_len_r     <= 8'(beats_s - 9'd1);
            beats_r      <= beats_s;
        end else if (ar_hs_s) begin
            ar_valid_r   <= 1'b0;
            if (line_end_s) begin
                line_r      <= line_r + 16'd1;
                off_r       <= 16'd0;
                line_addr_r <= line_addr_r + AxiAddrWidth'(stride_r);
                full_r      <= last_line_s;
            end else begin
                off_r       <= off_adv_s[15:0];
            end
        end
    end

    // Beats requested but not yet written, and bursts not yet closed by RLAST.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_r    <= {CntW{1'b0}};
            outstanding_r <= {OutW{1'b0}};
        end else begin
            inflight_r    <= inflight_r + (ar_hs_s ? CntW'(beats_r) : {CntW{1'b0}})
                                        - (axi.r_beat ? CntW'(1'b1) : {CntW{1'b0}});
            outstanding_r <= outstanding_r + (ar_hs_s ? OutW'(1'b1) : {OutW{1'b0}})
                                           - ((axi.r_beat & axi.r_last) ? OutW'(1'b1) : {OutW{1'b0}});
        end
    end

    assign axi.ar_addr  = ar_addr_r;
    assign axi.ar_len   = ar_len_r;
    assign axi.ar_valid = ar_valid_r;
    assign busy_o       = busy_r;
    assign frame_done_o = frame_done_r;
    assign late_o       = late_r;
    assign cfg_err_o    = cfg_err_r;
endmodule

// File: tb/tb_paper_fetch_sched.sv
// Scoreboard bench for paper_fetch_sched: a frame model predicts the AR burst list,
// a monitor checks every handshake, credit and outstanding limits.
module tb_paper_fetch_sched;
    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic        clk = 1'b0;
    logic        rst, en, frame_start;
    logic [63:0] fb_base;
    logic [15:0] line_bytes, stride, lines;
    logic [9:0]  fifo_fill;
    logic        busy, frame_done, late, cfg_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_cnt   = 0;
    int   seen_done = 0;
    int   outst_m  = 0;
    int   infl_m   = 0;
    int   ready_mode = 0;
    int   r_allow  = -1;
    int   beat_cnt = 0;
    ar_t  exp_q[$];
    int   rq[$];

    always #5 clk = ~clk;

    paper_fetch_sched_if #(.AddrWidth(64)) bus ();

    paper_fetch_sched #(
        .AxiAddrWidth(64), .AxiDataWidth(64), .BurstLen(16), .FifoDepth(512), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .fb_base_i(fb_base),
        .line_bytes_i(line_bytes), .stride_i(stride), .lines_i(lines),
        .frame_start_i(frame_start), .fifo_fill_i(fifo_fill), .axi(bus),
        .busy_o(busy), .frame_done_o(frame_done), .late_o(late), .cfg_err_o(cfg_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        n_checks++;
        if (act > lim) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required<=%0d", name, act, lim);
        end
    endtask

    // Reference model: split each line into bursts capped by 16 beats and the 4 KiB page.
    task automatic push_frame(input logic [63:0] base, input int lb, input int st, input int nl);
        logic [63:0] la, a;
        int off, b, room;
        ar_t e;
        for (int l = 0; l < nl; l++) begin
            la  = base + 64'(l) * 64'(st);
            off = 0;
            while (off < lb) begin
                a    = la + 64'(off);
                b    = 16;
                if ((lb - off) / 8 < b) b = (lb - off) / 8;
                room = (4096 - int'(a[11:0])) / 8;
                if (room < b) b = room;
                e.addr = a;
                e.len  = 8'(b - 1);
                exp_q.push_back(e);
                off += b * 8;
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [63:0] base, input int lb, input int st, input int nl);
        fb_base     = base;
        line_bytes  = 16'(lb);
        stride      = 16'(st);
        lines       = 16'(nl);
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (seen_done < target && k < 4000) begin
            wait_cyc(1);
            k++;
        end
        check("frame_done_count", 64'(seen_done), 64'(target));
    endtask

    task automatic finish_frame(input int target);
        wait_done(target);
        wait_cyc(3);
        check("frame_done_once", 64'(seen_done), 64'(target));
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("busy_after_frame", 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input logic [63:0] base, input int lb, input int st, input int nl);
        int d0 = seen_done;
        push_frame(base, lb, st, nl);
        start_frame(base, lb, st, nl);
        finish_frame(d0 + 1);
    endtask

    // Monitor: AR handshakes against the scoreboard, plus credit/outstanding bookkeeping.
    always @(negedge clk) begin
        ar_t e;
        if (!rst) begin
            if (bus.ar_valid && bus.ar_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ar: actual addr=%0h len=%0d required none", bus.ar_addr, bus.ar_len);
                end else begin
                    e = exp_q.pop_front();
                    check("ar_addr", bus.ar_addr, e.addr);
                    check("ar_len", 64'(bus.ar_len), 64'(e.len));
                end
                check_le("outstanding_before_ar", outst_m, 3);
                check_le("fifo_credit", int'(fifo_fill) + infl_m + int'(bus.ar_len) + 1, 512);
                rq.push_back(int'(bus.ar_len) + 1);
                outst_m++;
                infl_m += int'(bus.ar_len) + 1;
            end
            if (bus.r_beat) begin
                infl_m--;
                if (bus.r_last) outst_m--;
            end
            if (frame_done) seen_done++;
        end
    end

    // Slave side: randomised AR ready and an R-beat source with optional burst budget.
    initial begin
        bus.ar_ready = 1'b0;
        bus.r_beat   = 1'b0;
        bus.r_last   = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       bus.ar_ready = ($urandom_range(0, 3) != 0);
                1:       bus.ar_ready = 1'b0;
                default: bus.ar_ready = 1'b1;
            endcase
            if (rq.size() > 0 && r_allow != 0 && $urandom_range(0, 3) != 0) begin
                bus.r_beat = 1'b1;
                beat_cnt++;
                if (beat_cnt == rq[0]) begin
                    bus.r_last = 1'b1;
                    void'(rq.pop_front());
                    beat_cnt = 0;
                    if (r_allow > 0) r_allow--;
                end else begin
                    bus.r_last = 1'b0;
                end
            end else begin
                bus.r_beat = 1'b0;
                bus.r_last = 1'b0;
            end
        end
    end

    initial begin
        int hs0, d0, k;
        rst = 1'b1; en = 1'b0; frame_start = 1'b0; fifo_fill = 10'd0;
        fb_base = 64'd0; line_bytes = 16'd0; stride = 16'd0; lines = 16'd0;
        wait_cyc(3);
        check("rst_ar_valid", 64'(bus.ar_valid), 64'd0);
        check("rst_ar_addr", bus.ar_addr, 64'd0);
        check("rst_ar_len", 64'(bus.ar_len), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_late", 64'(late), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        rst = 1'b0;
        en  = 1'b1;
        wait_cyc(3);

        // Basic frame with AR latency check: 4 bursts of 16 beats, 0x80 apart.
        push_frame(64'h8000_0000, 256, 256, 2);
        start_frame(64'h8000_0000, 256, 256, 2);
        check("latency_calc_no_valid", 64'(bus.ar_valid), 64'd0);
        check("latency_calc_busy", 64'(busy), 64'd1);
        wait_cyc(1);
        check("latency_req_valid", 64'(bus.ar_valid), 64'd1);
        finish_frame(1);

        // 4 KiB split, and an address wrapping through zero.
        run_frame(64'h8000_0FC0, 128, 128, 1);
        run_frame(64'hFFFF_FFFF_FFFF_FF80, 256, 256, 1);

        // FIFO credit throttling with R held off.
        r_allow = 0; fifo_fill = 10'd500; hs0 = hs_cnt; d0 = seen_done;
        push_frame(64'h9000_0000, 256, 256, 1);
        start_frame(64'h9000_0000, 256, 256, 1);
        wait_cyc(20);
        check("credit_block_hs", 64'(hs_cnt - hs0), 64'd0);
        check("credit_block_valid", 64'(bus.ar_valid), 64'd0);
        fifo_fill = 10'd496;
        wait_cyc(20);
        check("credit_one_burst", 64'(hs_cnt - hs0), 64'd1);
        fifo_fill = 10'd0; r_allow = -1;
        finish_frame(d0 + 1);

        // Outstanding-burst limit.
        r_allow = 0; hs0 = hs_cnt; d0 = seen_done;
        push_frame(64'hA000_0000, 1024, 1024, 1);
        start_frame(64'hA000_0000, 1024, 1024, 1);
        wait_cyc(60);
        check("outstanding_cap", 64'(hs_cnt - hs0), 64'd4);
        r_allow = 1;
        wait_cyc(60);
        check("outstanding_after_rlast", 64'(hs_cnt - hs0), 64'd5);
        r_allow = -1;
        finish_frame(d0 + 1);

        // Late frame_start ignored mid-frame; then a bad config.
        hs0 = hs_cnt; d0 = seen_done; k = 0;
        push_frame(64'hB000_0000, 256, 512, 4);
        start_frame(64'hB000_0000, 256, 512, 4);
        while (hs_cnt < hs0 + 2 && k < 500) begin wait_cyc(1); k++; end
        start_frame(64'hB100_0000, 8, 8, 1);
        check("late_set", 64'(late), 64'd1);
        finish_frame(d0 + 1);
        hs0 = hs_cnt;
        start_frame(64'hB200_0000, 12, 16, 1);
        wait_cyc(20);
        check("cfg_err_set", 64'(cfg_err), 64'd1);
        check("cfg_err_no_ar", 64'(hs_cnt - hs0), 64'd0);
        check("cfg_err_not_busy", 64'(busy), 64'd0);
        check("late_sticky", 64'(late), 64'd1);
        en = 1'b0; wait_cyc(2); en = 1'b1; wait_cyc(2);
        check("late_cleared", 64'(late), 64'd0);
        check("cfg_err_cleared", 64'(cfg_err), 64'd0);
        start_frame(64'hB300_0004, 64, 64, 1);
        wait_cyc(5);
        check("cfg_err_base_misaligned", 64'(cfg_err), 64'd1);
        en = 1'b0; wait_cyc(2); en = 1'b1; wait_cyc(2);

        // Enable dropped while a request is stalled: request holds, then abort to IDLE.
        ready_mode = 1; hs0 = hs_cnt; d0 = seen_done; k = 0;
        push_frame(64'hC000_0000, 512, 512, 2);
        start_frame(64'hC000_0000, 512, 512, 2);
        while (!bus.ar_valid && k < 50) begin wait_cyc(1); k++; end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_cyc(1);
            check("abort_valid_held", 64'(bus.ar_valid), 64'd1);
            check("abort_addr_stable", bus.ar_addr, exp_q[0].addr);
            check("abort_len_stable", 64'(bus.ar_len), 64'(exp_q[0].len));
        end
        ready_mode = 2; k = 0;
        while (hs_cnt == hs0 && k < 20) begin wait_cyc(1); k++; end
        check("abort_one_hs", 64'(hs_cnt - hs0), 64'd1);
        exp_q.delete();
        ready_mode = 0; k = 0;
        while (busy && k < 500) begin wait_cyc(1); k++; end
        wait_cyc(3);
        check("abort_not_busy", 64'(busy), 64'd0);
        check("abort_no_frame_done", 64'(seen_done), 64'(d0));
        check("abort_no_more_ar", 64'(hs_cnt - hs0), 64'd1);
        en = 1'b1;
        wait_cyc(3);

        // Randomised frames under random ready, R gaps and FIFO fill.
        for (int f = 0; f < 8; f++) begin
            logic [63:0] b;
            int lb, st, nl;
            fifo_fill = 10'($urandom_range(0, 300));
            b  = 64'h4_0000_0000 + 64'(8 * $urandom_range(0, 1023)) + 64'(4096 * $urandom_range(0, 3));
            lb = 8 * $urandom_range(1, 80);
            st = lb + 8 * $urandom_range(0, 40);
            nl = $urandom_range(1, 4);
            run_frame(b, lb, st, nl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
